// File: rtl/fifo_stream_reader_pkg.sv
// Shared definitions for the FIFO stream reader and its skid buffer.
// State encodings and skid depth live here so other stream blocks agree.
package fifo_stream_reader_pkg;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_DRAIN = 2'd1
    } state_t;

    localparam int SKID_DEPTH = 2;

endpackage

// File: rtl/fifo_stream_reader_skid2.sv
// stream_skid2: two-entry FIFO with push/pop, occupancy count and head data.
// A push into a full buffer is accepted only when a pop happens the same clock.
module stream_skid2
    import fifo_stream_reader_pkg::*;
#(
    parameter int pDATA_WIDTH = 8
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic                   flush_i,
    input  logic                   push_i,
    input  logic [pDATA_WIDTH-1:0] data_i,
    input  logic                   pop_i,
    output logic [1:0]             cnt_o,
    output logic [pDATA_WIDTH-1:0] head_o
);

    logic [pDATA_WIDTH-1:0] mem_q [SKID_DEPTH];
    logic                   wr_q;
    logic                   rd_q;
    logic [1:0]             cnt_q;
    logic [1:0]             cnt_d;
    logic                   do_pop;
    logic                   do_push;

    assign do_pop  = pop_i && (cnt_q != 2'd0);
    assign do_push = push_i && ((cnt_q != 2'(SKID_DEPTH)) || do_pop);
    assign cnt_d   = cnt_q + {1'b0, do_push} - {1'b0, do_pop};

    always_ff @(posedge clk) begin
        if (reset || flush_i) begin
            wr_q  <= 1'b0;
            rd_q  <= 1'b0;
            cnt_q <= 2'd0;
        end else begin
            if (do_push) begin
                mem_q[wr_q] <= data_i;
                wr_q        <= ~wr_q;
            end
            if (do_pop) begin
                rd_q <= ~rd_q;
            end
            cnt_q <= cnt_d;
        end
    end

    assign cnt_o  = cnt_q;
    assign head_o = mem_q[rd_q];

endmodule

// File: rtl/fifo_stream_reader.sv
// Drains a commanded burst from a registered-output sync FIFO onto a
// valid/ready stream, hiding the read latency with a 2-entry skid buffer.
module fifo_stream_reader
    import fifo_stream_reader_pkg::*;
#(
    parameter int pDATA_WIDTH  = 8,
    parameter int pCOUNT_WIDTH = 16
) (
    input  logic                    clk,
    input  logic                    reset,
    input  logic                    start,
    input  logic [pCOUNT_WIDTH-1:0] burst_len,
    input  logic                    abort,
    output logic                    busy,
    output logic                    done,
    output logic                    aborted,
    output logic                    error,
    output logic [pCOUNT_WIDTH-1:0] words_sent,
    output logic                    fifo_ren,
    input  logic                    fifo_empty,
    input  logic [pDATA_WIDTH-1:0]  fifo_rdata,
    input  logic                    fifo_underflow,
    output logic                    m_valid,
    input  logic                    m_ready,
    output logic [pDATA_WIDTH-1:0]  m_data,
    output logic                    m_last
);

    state_t                  state_q, state_d;
    logic [pCOUNT_WIDTH-1:0] rd_left_q, rd_left_d;
    logic [pCOUNT_WIDTH-1:0] out_left_q, out_left_d;
    logic [pCOUNT_WIDTH-1:0] words_q, words_d;
    logic                    in_flight_q;
    logic                    empty_q;
    logic                    done_q, done_d;
    logic                    aborted_q, aborted_d;
    logic                    error_q, error_d;

    logic [1:0]             skid_cnt;
    logic [1:0]             cnt_next;
    logic [pDATA_WIDTH-1:0] skid_head;
    logic                   drain;
    logic                   handshake;
    logic                   last_hs;
    logic                   abort_take;
    logic                   ren;

    assign drain     = (state_q == ST_DRAIN);
    assign m_valid   = (skid_cnt != 2'd0);
    assign handshake = m_valid && m_ready;
    assign cnt_next  = skid_cnt - {1'b0, handshake};
    assign last_hs   = handshake && (out_left_q == pCOUNT_WIDTH'(1));
    // Completing the final handshake takes priority over a coincident abort.
    assign abort_take = drain && abort && !last_hs;

    assign ren = drain && !abort && !fifo_empty
              && (rd_left_q != '0)
              && (({1'b0, cnt_next} + {2'b00, in_flight_q}) <= 3'd1);

    stream_skid2 #(
        .pDATA_WIDTH(pDATA_WIDTH)
    ) u_skid (
        .clk    (clk),
        .reset  (reset),
        .flush_i(abort_take),
        .push_i (in_flight_q && !abort_take),
        .data_i (fifo_rdata),
        .pop_i  (handshake),
        .cnt_o  (skid_cnt),
        .head_o (skid_head)
    );

    always_comb begin
        state_d    = state_q;
        rd_left_d  = rd_left_q - pCOUNT_WIDTH'(ren);
        out_left_d = out_left_q - pCOUNT_WIDTH'(handshake);
        words_d    = words_q;
        done_d     = 1'b0;
        aborted_d  = 1'b0;
        error_d    = error_q;
        if (handshake && (words_q != '1)) begin
            words_d = words_q + pCOUNT_WIDTH'(1);
        end
        if ((drain && fifo_underflow) || (in_flight_q && empty_q)) begin
            error_d = 1'b1;
        end
        unique case (state_q)
            ST_IDLE: begin
                if (start && !abort) begin
                    error_d = 1'b0;
                    words_d = '0;
                    if (burst_len == '0) begin
                        done_d = 1'b1;
                    end else begin
                        state_d    = ST_DRAIN;
                        rd_left_d  = burst_len;
                        out_left_d = burst_len;
                    end
                end
            end
            ST_DRAIN: begin
                if (last_hs) begin
                    state_d = ST_IDLE;
                    done_d  = 1'b1;
                end else if (abort) begin
                    state_d   = ST_IDLE;
                    aborted_d = 1'b1;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q     <= ST_IDLE;
            rd_left_q   <= '0;
            out_left_q  <= '0;
            words_q     <= '0;
            in_flight_q <= 1'b0;
            empty_q     <= 1'b1;
            done_q      <= 1'b0;
            aborted_q   <= 1'b0;
            error_q     <= 1'b0;
        end else begin
            state_q     <= state_d;
            rd_left_q   <= rd_left_d;
            out_left_q  <= out_left_d;
            words_q     <= words_d;
            in_flight_q <= ren;
            empty_q     <= fifo_empty;
            done_q      <= done_d;
            aborted_q   <= aborted_d;
            error_q     <= error_d;
        end
    end

    assign busy       = drain;
    assign done       = done_q;
    assign aborted    = aborted_q;
    assign error      = error_q;
    assign words_sent = words_q;
    assign fifo_ren   = ren;
    assign m_data     = skid_head;
    assign m_last     = m_valid && (out_left_q == pCOUNT_WIDTH'(1));

endmodule
